usb_uart_out_ep_reader: RTL and testbench

Host-to-device half of the USB serial bridge. Arbitrates for the USB OUT endpoint buffer, drains received bulk bytes into a small FIFO, and presents them to the UART-side consumer through a valid/read-enable interface. Sits beside the IN-direction bridge endpoint, between the USB protocol engine's OUT endpoint port and the CPU/UART register block.

---
 rtl/usb_uart_pkg.sv | 18 +
 rtl/usb_uart_fifo.sv | 74 +++++++
 rtl/usb_uart_out_ep_reader.sv | 131 +++++++++++++
 tb/tb_usb_uart_out_ep_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_pkg.sv
// Shared definitions for the USB serial bridge (OUT and IN directions).
package usb_uart_pkg;

    // Default FIFO depth for the bridge endpoints
    localparam int DEPTH_DEFAULT = 16;

    // One byte on the UART side of the bridge
    typedef logic [7:0] uart_byte_t;

    // Endpoint buffer ownership state machine
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        READ    = 2'd2,
        RELEASE = 2'd3
    } ep_state_e;

endpackage

// File: rtl/usb_uart_fifo.sv
// Synchronous byte FIFO with head-of-queue read; rdata is 8'h00 when empty.
module usb_uart_fifo
    import usb_uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  uart_byte_t  wdata,
    input  logic        pop,
    output uart_byte_t  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    uart_byte_t    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          pop_s;
    logic          push_s;

    // Qualify requests: pop only when data exists, push only when room (or a pop frees it)
    always_comb begin
        pop_s  = pop && (count_r != {(AW+1){1'b0}});
        push_s = push && ((count_r != DEPTH_C) || pop_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head-of-queue view and status flags
    always_comb begin
        empty = (count_r == {(AW+1){1'b0}});
        full  = (count_r == DEPTH_C);
        count = count_r;
        if (empty) begin
            rdata = 8'h00;
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/usb_uart_out_ep_reader.sv
// Host-to-device half of the USB serial bridge: owns the OUT endpoint buffer,
// drains received bytes into a FIFO and hands them to the UART-side consumer.
module usb_uart_out_ep_reader
    import usb_uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    output logic        out_ep_req,
    input  logic        out_ep_grant,
    input  logic        out_ep_data_avail,
    input  logic        out_ep_setup,
    output logic        out_ep_data_get,
    input  logic [7:0]  out_ep_data,
    output logic        out_ep_stall,
    input  logic        out_ep_acked,
    input  logic        uart_re,
    output logic [7:0]  uart_do,
    output logic        uart_valid,
    output logic [AW:0] uart_count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    ep_state_e   state_r;
    logic        pending_r;   // byte on the bus this cycle, written into the FIFO at the next edge
    logic [AW:0] count_s;
    logic        full_s;
    logic        empty_s;
    uart_byte_t  head_s;
    logic        room_s;
    logic        issue_s;
    logic        done_s;
    logic        ep_unused_s;

    // SETUP marking and ACK status carry no meaning for this direction
    assign ep_unused_s  = out_ep_setup ^ out_ep_acked;
    assign out_ep_stall = 1'b0;

    usb_uart_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pending_r),
        .wdata (out_ep_data),
        .pop   (uart_re),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Consumer-side view is straight from the FIFO state
    always_comb begin
        uart_do    = head_s;
        uart_valid = !empty_s;
        uart_count = count_s;
    end

    // Get decision: room counts the byte about to be captured but ignores a same-cycle pop.
    // A get is never issued while the previous one is still on the strobe, giving one byte
    // per two clocks; the capture cycle itself may issue the next get.
    always_comb begin
        room_s  = (count_s + {{AW{1'b0}}, pending_r}) < DEPTH_C;
        issue_s = out_ep_grant && out_ep_data_avail && !out_ep_data_get && room_s;
        done_s  = !pending_r && !out_ep_data_get && !out_ep_data_avail;
    end

    // Ownership FSM with registered request/strobe; capture tracking runs in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            out_ep_req      <= 1'b0;
            out_ep_data_get <= 1'b0;
            pending_r       <= 1'b0;
        end else begin
            pending_r <= out_ep_data_get;
            case (state_r)
                IDLE: begin
                    out_ep_data_get <= 1'b0;
                    if (out_ep_data_avail && !full_s) begin
                        state_r    <= REQ;
                        out_ep_req <= 1'b1;
                    end else begin
                        out_ep_req <= 1'b0;
                    end
                end
                REQ: begin
                    out_ep_req <= 1'b1;
                    if (out_ep_grant) begin
                        state_r         <= READ;
                        out_ep_data_get <= issue_s;
                    end else begin
                        out_ep_data_get <= 1'b0;
                    end
                end
                READ: begin
                    if (!out_ep_grant) begin
                        // lost ownership: any byte already on the bus is still captured
                        state_r         <= IDLE;
                        out_ep_req      <= 1'b0;
                        out_ep_data_get <= 1'b0;
                    end else if (done_s) begin
                        // drop the request now so the buffer returns promptly
                        state_r         <= RELEASE;
                        out_ep_req      <= 1'b0;
                        out_ep_data_get <= 1'b0;
                    end else begin
                        out_ep_req      <= 1'b1;
                        out_ep_data_get <= issue_s;
                    end
                end
                RELEASE: begin
                    state_r         <= IDLE;
                    out_ep_req      <= 1'b0;
                    out_ep_data_get <= 1'b0;
                end
                default: begin
                    state_r         <= IDLE;
                    out_ep_req      <= 1'b0;
                    out_ep_data_get <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_uart_out_ep_reader.sv
// Directed bench for usb_uart_out_ep_reader with a behavioural OUT endpoint and byte scoreboard.
module tb_usb_uart_out_ep_reader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ep_req;
    logic        out_ep_grant;
    logic        out_ep_data_avail;
    logic        out_ep_setup;
    logic        out_ep_data_get;
    logic [7:0]  out_ep_data;
    logic        out_ep_stall;
    logic        out_ep_acked;
    logic        uart_re;
    logic [7:0]  uart_do;
    logic        uart_valid;
    logic [AW:0] uart_count;

    int checks = 0;
    int errors = 0;

    // endpoint model state
    logic [7:0] pkt [0:127];
    int         pkt_len   = 0;
    int         pkt_start = 0;
    int         ep_rd     = 0;
    logic       grant_en  = 1'b1;

    // monitors
    logic [7:0] exp_q [$];
    int         n_get       = 0;
    int         viol_consec = 0;
    int         viol_full   = 0;
    int         req_drop    = 0;
    int         max_count   = 0;
    logic       get_prev    = 1'b0;
    logic       watch_req   = 1'b0;

    usb_uart_out_ep_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked),
        .uart_re           (uart_re),
        .uart_do           (uart_do),
        .uart_valid        (uart_valid),
        .uart_count        (uart_count)
    );

    always #5 clk = ~clk;

    assign out_ep_grant      = grant_en & out_ep_req;
    assign out_ep_data_avail = ((ep_rd - pkt_start) < pkt_len);

    // Endpoint: byte appears the cycle after a get strobe
    always @(posedge clk) begin
        if (out_ep_data_get) begin
            out_ep_data <= pkt[(ep_rd - pkt_start) & 127];
            ep_rd       <= ep_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard on pops plus protocol monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (uart_re && uart_valid) begin
            if (exp_q.size() == 0) chk("pop_extra", 32'(uart_do), 32'hFFFF_FFFF);
            else chk("pop_data", 32'(uart_do), 32'(exp_q.pop_front()));
        end
        if (out_ep_data_get) n_get++;
        if (out_ep_data_get && get_prev) viol_consec++;
        if (out_ep_data_get && (int'(uart_count) >= DEPTH)) viol_full++;
        if (watch_req && out_ep_data_avail && !out_ep_req) req_drop++;
        if (int'(uart_count) > max_count) max_count = int'(uart_count);
        get_prev = out_ep_data_get;
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) begin
            pkt[i] = first + 8'(i);
            exp_q.push_back(first + 8'(i));
        end
        pkt_start = ep_rd;
        pkt_len   = len;
    endtask

    task automatic drain(input int budget);
        uart_re = 1'b1;
        for (int i = 0; i < budget; i++) drive_step();
        uart_re = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_step();
    endtask

    initial begin
        reset        = 1'b1;
        uart_re      = 1'b0;
        out_ep_setup = 1'b0;
        out_ep_acked = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_req",   32'(out_ep_req), 32'd0);
        chk("rst_get",   32'(out_ep_data_get), 32'd0);
        chk("rst_stall", 32'(out_ep_stall), 32'd0);
        chk("rst_valid", 32'(uart_valid), 32'd0);
        chk("rst_do",    32'(uart_do), 32'h00);
        chk("rst_count", 32'(uart_count), 32'd0);
        drive_step();
        reset = 1'b0;
        idle(2);

        // single byte 8'h41, consumer idle; SETUP flag set to show it is ignored
        out_ep_setup = 1'b1;
        load_pkt(8'h41, 1);
        @(negedge clk);                                   // cycle 0
        @(negedge clk); chk("lat_req",  32'(out_ep_req), 32'd1);
        @(negedge clk); chk("lat_get",  32'(out_ep_data_get), 32'd1);
        @(negedge clk); chk("lat_cap_valid", 32'(uart_valid), 32'd0);
        @(negedge clk);
        chk("one_valid", 32'(uart_valid), 32'd1);
        chk("one_do",    32'(uart_do), 32'h41);
        chk("one_count", 32'(uart_count), 32'd1);
        @(negedge clk); chk("one_release", 32'(out_ep_req), 32'd0);
        chk("one_stall", 32'(out_ep_stall), 32'd0);
        out_ep_setup = 1'b0;
        drive_step();
        uart_re = 1'b1;
        drive_step();
        uart_re = 1'b0;
        @(negedge clk); chk("one_popped", 32'(uart_count), 32'd0);

        // consumer reads an empty FIFO
        drive_step();
        uart_re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("empty_count", 32'(uart_count), 32'd0);
            chk("empty_do",    32'(uart_do), 32'h00);
        end
        drive_step();
        uart_re = 1'b0;

        // 64-byte packet, pop every 10 cycles, FIFO saturates
        n_get = 0; viol_consec = 0; viol_full = 0; req_drop = 0; max_count = 0;
        drive_step();
        load_pkt(8'h00, 64);
        for (int i = 0; i < 10 && !out_ep_req; i++) @(negedge clk);
        chk("burst_req_up", 32'(out_ep_req), 32'd1);
        watch_req = 1'b1;
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) begin
            drive_step();
            uart_re = ((k % 10) == 9);
        end
        drive_step();
        uart_re   = 1'b0;
        watch_req = 1'b0;
        chk("burst_all_popped", 32'(exp_q.size()), 32'd0);
        chk("burst_gets",       32'(n_get), 32'd64);
        chk("burst_max_count",  32'(max_count), 32'(DEPTH));
        chk("burst_no_full_get", 32'(viol_full), 32'd0);
        chk("burst_no_b2b_get",  32'(viol_consec), 32'd0);
        chk("burst_req_held",    32'(req_drop), 32'd0);
        @(negedge clk); chk("burst_empty", 32'(uart_count), 32'd0);

        // fill to DEPTH-1, then pop exactly on the capture cycle of one more byte
        drive_step();
        load_pkt(8'hA0, 15);
        idle(45);
        @(negedge clk);
        chk("near_full_count", 32'(uart_count), 32'(DEPTH - 1));
        chk("near_full_idle",  32'(out_ep_req), 32'd0);
        drive_step();
        load_pkt(8'hB0, 1);                              // cycle 0
        drive_step(); drive_step(); drive_step();        // into cycle 3: capture cycle
        uart_re = 1'b1;
        @(negedge clk); chk("cap_cycle_get_done", 32'(out_ep_data_get), 32'd0);
        drive_step();
        uart_re = 1'b0;
        @(negedge clk); chk("cap_pop_count", 32'(uart_count), 32'(DEPTH - 1));
        drive_step();
        drain(20);

        // reset while a get is on the strobe
        n_get = 0;
        drive_step();
        load_pkt(8'h10, 5);
        for (int i = 0; i < 10 && n_get == 0; i++) @(negedge clk);
        chk("rst_mid_get_seen", 32'(n_get), 32'd1);
        #1 reset = 1'b1;
        #1 chk("rst_async_req", 32'(out_ep_req), 32'd0);
        @(negedge clk);
        chk("rst_mid_req",   32'(out_ep_req), 32'd0);
        chk("rst_mid_get",   32'(out_ep_data_get), 32'd0);
        chk("rst_mid_count", 32'(uart_count), 32'd0);
        exp_q.delete();
        pkt_len = 0;
        drive_step();
        reset = 1'b0;
        idle(2);
        load_pkt(8'h55, 1);
        idle(6);
        @(negedge clk);
        chk("after_rst_count", 32'(uart_count), 32'd1);
        chk("after_rst_do",    32'(uart_do), 32'h55);
        drive_step();
        drain(4);

        // grant withdrawn with three bytes left in the packet
        n_get = 0;
        drive_step();
        load_pkt(8'h60, 6);
        for (int i = 0; i < 20 && n_get < 3; i++) @(negedge clk);
        chk("gd_three_gets", 32'(n_get), 32'd3);
        #1 grant_en = 1'b0;
        idle(8);
        @(negedge clk);
        chk("gd_no_more_gets", 32'(n_get), 32'd3);
        chk("gd_count",        32'(uart_count), 32'd3);
        chk("gd_rerequest",    32'(out_ep_req), 32'd1);
        drive_step();
        grant_en = 1'b1;
        drain(30);
        chk("gd_total_gets", 32'(n_get), 32'd6);
        chk("gd_no_b2b",     32'(viol_consec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
